// File: rtl/rv32_writeback_unit_if.sv
// -----------------------------------------------------------------------------
// rv32_writeback_unit_if
// Purpose : Result-delivery bus from the execute/memory stages into the
//           write-back unit. It carries two independent valid/ready channels:
//           the single-cycle ALU result and the load/store unit result.
// Signals :
//   alu_valid_i / alu_rd_i / alu_data_i   ALU result offered by the producer
//   alu_ready_o                           ALU result accepted (valid & ready)
//   lsu_valid_i / lsu_rd_i / lsu_data_i   raw aligned load word and its target
//   lsu_funct3_i / lsu_addr_lo_i          load size/sign and byte offset
//   lsu_ready_o                           load result accepted (valid & ready)
// Modports:
//   master : the producing pipeline stages (drive valid/payload, see ready)
//   slave  : the write-back unit (sees valid/payload, drives ready)
// -----------------------------------------------------------------------------
interface rv32_writeback_unit_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               alu_valid_i;
    logic [RADDR_W-1:0] alu_rd_i;
    logic [XLEN-1:0]    alu_data_i;
    logic               alu_ready_o;

    logic               lsu_valid_i;
    logic [RADDR_W-1:0] lsu_rd_i;
    logic [XLEN-1:0]    lsu_data_i;
    logic [2:0]         lsu_funct3_i;
    logic [1:0]         lsu_addr_lo_i;
    logic               lsu_ready_o;

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i, lsu_funct3_i, lsu_addr_lo_i,
        input  alu_ready_o, lsu_ready_o
    );

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i, lsu_funct3_i, lsu_addr_lo_i,
        output alu_ready_o, lsu_ready_o
    );
endinterface

// File: rtl/rv32_writeback_unit.sv
// -----------------------------------------------------------------------------
// rv32_writeback_unit
// Purpose : Write-side master of the RV32 register file. Accepts ALU results
//           and load results, formats loads by size/sign/byte lane, arbitrates
//           the two sources (ALU first, colliding load parked in a one-entry
//           hold register) and drives the register-file write port from
//           registered outputs, one cycle after acceptance.
// Ports   :
//   clk_i, rst_i        clock; synchronous active-high reset
//   bus (slave)         ALU and LSU valid/ready channels
//   write_reg_addr/data register-file write address/data (hold when wen=0)
//   wen                 one-cycle write strobe
//   load_err_o          one-cycle pulse for a misaligned / illegal load
//   busy_o              high while a load is parked in the hold register
// Option  : RV32_WB_FWD_EN adds rs1/rs2 bypass ports that expose the write
//           currently being performed so decode can skip the regfile cycle.
// -----------------------------------------------------------------------------
module rv32_writeback_unit #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rv32_writeback_unit_if.slave bus,
    output logic [RADDR_W-1:0]  write_reg_addr,
    output logic [XLEN-1:0]     write_reg_data,
    output logic                wen,
    output logic                load_err_o,
    output logic                busy_o
`ifdef RV32_WB_FWD_EN
    ,
    input  logic [RADDR_W-1:0]  rs1_addr_i,
    input  logic [RADDR_W-1:0]  rs2_addr_i,
    output logic                rs1_fwd_hit_o,
    output logic [XLEN-1:0]     rs1_fwd_data_o,
    output logic                rs2_fwd_hit_o,
    output logic [XLEN-1:0]     rs2_fwd_data_o
`endif
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    localparam logic [RADDR_W-1:0] RD_ZERO = {RADDR_W{1'b0}};

    // Extract and extend the addressed byte/half/word of a raw load word.
    function automatic logic [XLEN-1:0] fmt_load(
        input logic [2:0]      f3,
        input logic [1:0]      lo,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [XLEN-1:0] res;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{(XLEN-8){b[7]}}, b};
            3'b100:  res = {{(XLEN-8){1'b0}}, b};
            3'b001:  res = {{(XLEN-16){h[15]}}, h};
            3'b101:  res = {{(XLEN-16){1'b0}}, h};
            3'b010:  res = word;
            default: res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    // A load is rejected for an unknown funct3 or an offset that is not
    // naturally aligned to its access size.
    function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = lo[0];
            3'b010:         bad = (lo != 2'd0);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;

    logic [RADDR_W-1:0] r_hold_rd;
    logic [XLEN-1:0]    r_hold_data;
    logic               r_hold_err;

    logic               r_wen;
    logic [RADDR_W-1:0] r_waddr;
    logic [XLEN-1:0]    r_wdata;
    logic               r_load_err;

    logic               w_alu_ready;
    logic               w_lsu_ready;
    logic               w_busy;
    logic               w_alu_fire;
    logic               w_lsu_fire;
    logic [XLEN-1:0]    w_lsu_fmt;
    logic               w_lsu_err;

    logic               w_wen_nxt;
    logic [RADDR_W-1:0] w_waddr_nxt;
    logic [XLEN-1:0]    w_wdata_nxt;
    logic               w_err_nxt;

    assign w_alu_fire = bus.alu_valid_i && w_alu_ready;
    assign w_lsu_fire = bus.lsu_valid_i && w_lsu_ready;
    assign w_lsu_fmt  = fmt_load(bus.lsu_funct3_i, bus.lsu_addr_lo_i, bus.lsu_data_i);
    assign w_lsu_err  = load_bad(bus.lsu_funct3_i, bus.lsu_addr_lo_i);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a same-cycle ALU+LSU acceptance parks the load for one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_alu_fire && w_lsu_fire) begin
                    w_state_nxt = ST_HELD;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_HELD:  w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // State-decoded outputs: both channels accept only while nothing is held.
    always_comb begin
        w_alu_ready = 1'b0;
        w_lsu_ready = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_alu_ready = 1'b1;
                w_lsu_ready = 1'b1;
                w_busy      = 1'b0;
            end
            ST_HELD: begin
                w_alu_ready = 1'b0;
                w_lsu_ready = 1'b0;
                w_busy      = 1'b1;
            end
            default: begin
                w_alu_ready = 1'b0;
                w_lsu_ready = 1'b0;
                w_busy      = 1'b0;
            end
        endcase
    end

    assign bus.alu_ready_o = w_alu_ready;
    assign bus.lsu_ready_o = w_lsu_ready;
    assign busy_o          = w_busy;

    // Select what the write port does next cycle. Writes to x0 and erroring
    // loads are consumed but leave address/data untouched.
    always_comb begin
        w_wen_nxt   = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_alu_fire) begin
                    if (bus.alu_rd_i != RD_ZERO) begin
                        w_wen_nxt   = 1'b1;
                        w_waddr_nxt = bus.alu_rd_i;
                        w_wdata_nxt = bus.alu_data_i;
                    end else begin
                        w_wen_nxt   = 1'b0;
                    end
                end else if (w_lsu_fire) begin
                    if (w_lsu_err) begin
                        w_err_nxt   = 1'b1;
                    end else if (bus.lsu_rd_i != RD_ZERO) begin
                        w_wen_nxt   = 1'b1;
                        w_waddr_nxt = bus.lsu_rd_i;
                        w_wdata_nxt = w_lsu_fmt;
                    end else begin
                        w_wen_nxt   = 1'b0;
                    end
                end else begin
                    w_wen_nxt   = 1'b0;
                end
            end
            ST_HELD: begin
                if (r_hold_err) begin
                    w_err_nxt   = 1'b1;
                end else if (r_hold_rd != RD_ZERO) begin
                    w_wen_nxt   = 1'b1;
                    w_waddr_nxt = r_hold_rd;
                    w_wdata_nxt = r_hold_data;
                end else begin
                    w_wen_nxt   = 1'b0;
                end
            end
            default: begin
                w_wen_nxt   = 1'b0;
                w_err_nxt   = 1'b0;
            end
        endcase
    end

    // Registered write port and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wen      <= 1'b0;
            r_waddr    <= {RADDR_W{1'b0}};
            r_wdata    <= {XLEN{1'b0}};
            r_load_err <= 1'b0;
        end else begin
            r_wen      <= w_wen_nxt;
            r_waddr    <= w_waddr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_load_err <= w_err_nxt;
        end
    end

    // Hold register: captures the already-formatted load on a collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold_rd   <= {RADDR_W{1'b0}};
            r_hold_data <= {XLEN{1'b0}};
            r_hold_err  <= 1'b0;
        end else if ((r_state == ST_EMPTY) && w_alu_fire && w_lsu_fire) begin
            r_hold_rd   <= bus.lsu_rd_i;
            r_hold_data <= w_lsu_fmt;
            r_hold_err  <= w_lsu_err;
        end else begin
            r_hold_rd   <= r_hold_rd;
            r_hold_data <= r_hold_data;
            r_hold_err  <= r_hold_err;
        end
    end

    assign wen            = r_wen;
    assign write_reg_addr = r_waddr;
    assign write_reg_data = r_wdata;
    assign load_err_o     = r_load_err;

`ifdef RV32_WB_FWD_EN
    // Bypass: expose the write being performed this cycle to the decoder.
    always_comb begin
        rs1_fwd_hit_o  = r_wen && (r_waddr == rs1_addr_i) && (rs1_addr_i != RD_ZERO);
        rs2_fwd_hit_o  = r_wen && (r_waddr == rs2_addr_i) && (rs2_addr_i != RD_ZERO);
        if (rs1_fwd_hit_o) begin
            rs1_fwd_data_o = r_wdata;
        end else begin
            rs1_fwd_data_o = {XLEN{1'b0}};
        end
        if (rs2_fwd_hit_o) begin
            rs2_fwd_data_o = r_wdata;
        end else begin
            rs2_fwd_data_o = {XLEN{1'b0}};
        end
    end
`endif

endmodule

// File: doc/rv32_writeback_unit.md
Name: rv32_writeback_unit

Overview:
- Write-side master for the RV32 register file.
- Collects results from the single-cycle ALU path and the load/store unit (LSU), over separate valid/ready handshakes.
- Formats load data by size, sign and byte lane, arbitrates between the two sources, and drives the register file write port (write_reg_addr / write_reg_data / wen) from registered outputs.
- Sits between execute/memory stages and the register file.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- RADDR_W, 5, register address width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- alu_valid_i  in  1  ALU result valid.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  32  ALU result.
- alu_ready_o  out  1  ALU result accepted when valid&ready.
- lsu_valid_i  in  1  load result valid.
- lsu_rd_i  in  5  load destination register.
- lsu_data_i  in  32  raw aligned memory word.
- lsu_funct3_i  in  3  load funct3.
- lsu_addr_lo_i  in  2  byte address bits [1:0].
- lsu_ready_o  out  1  load result accepted when valid&ready.
- write_reg_addr  out  5  to regfile write address.
- write_reg_data  out  32  to regfile write data.
- wen  out  1  to regfile write enable.
- load_err_o  out  1  one-cycle pulse: accepted load was misaligned or had illegal funct3.
- busy_o  out  1  high in HELD state.

Behaviour:
- Reset (rst_i=1 at clock edge): state=EMPTY, hold register cleared, wen=0, write_reg_addr=0, write_reg_data=0, load_err_o=0.
- Reset mid-HELD discards the held load; no write is issued for it.
- Ready outputs are combinational from state only:
  - EMPTY: alu_ready_o=1, lsu_ready_o=1.
  - HELD: both 0.
- Latency: an accepted result drives wen/write_reg_* on the following cycle.
  - wen is high for exactly one cycle per write.
  - wen is 0 in any cycle with no write.
  - write_reg_addr/data hold their last value when wen=0.
- EMPTY transitions:
  - Only ALU valid: write ALU result; stay EMPTY.
  - Only LSU valid: write formatted load; stay EMPTY.
  - Both valid: write ALU result this cycle; capture formatted load (rd, data, err) into hold register; go to HELD.
  - Neither valid: no write.
- HELD: write held entry next cycle; go to EMPTY. No new acceptance while HELD.
- rd=0:
  - The handshake completes normally and the result is consumed.
  - wen stays 0 for that slot; write_reg_* are not updated.
- Load formatting (funct3 / addr_lo):
  - 000 LB: byte lane addr_lo, sign-extended.
  - 100 LBU: same lane, zero-extended.
  - 001 LH: half addr_lo[1], sign-extended.
  - 101 LHU: same half, zero-extended.
  - 010 LW: full word.
  - Lane 0 = bits [7:0]; half 0 = bits [15:0].
- Load errors:
  - Causes: LH/LHU with addr_lo[0]=1; LW with addr_lo≠0; funct3 ∈ {011, 110, 111}.
  - Effect: load is accepted, no write (wen=0), load_err_o=1 in the cycle the write would have occurred.
  - An erroring load still moves the FSM to HELD when it collides with an ALU result.
- ALU results are never modified.

Optional Feature:
- Macro: RV32_WB_FWD_EN.
- Defined: adds ports
  - rs1_addr_i in 5, rs2_addr_i in 5
  - rs1_fwd_hit_o out 1, rs1_fwd_data_o out 32
  - rs2_fwd_hit_o out 1, rs2_fwd_data_o out 32
- rsN_fwd_hit_o = wen && write_reg_addr==rsN_addr_i && rsN_addr_i≠0; combinational.
- rsN_fwd_data_o = write_reg_data when hit, else 0.
- Lets decode bypass the register-file write cycle.
- Undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
- Reset then idle:
  - alu_valid_i=1, alu_rd_i=5, alu_data_i=0x1234_5678 for one cycle → next cycle wen=1, write_reg_addr=5, write_reg_data=0x1234_5678.
  - Following cycle wen=0.
- Load formatting:
  - LB, lsu_data_i=0x80FF_7F01, addr_lo=3 → data 0xFFFF_FF80.
  - Same word, LBU addr_lo=3 → 0x0000_0080.
  - LH addr_lo=2 → 0xFFFF_80FF.
  - LW addr_lo=0 → 0x80FF_7F01.
- Collision:
  - ALU (rd=3, 0xA) and LSU LW (rd=4, 0xB) both valid in one cycle.
  - Cycle+1: write x3=0xA, busy_o=1, both ready=0.
  - Cycle+2: write x4=0xB, busy_o=0, both ready=1.
- rd=0:
  - ALU rd=0, data 0xDEAD → alu_ready_o=1, wen stays 0 next cycle.
- Errors:
  - LW addr_lo=2 → load_err_o=1 for one cycle, wen=0.
  - funct3=011 → same response.
- Reset mid-HELD:
  - Collision as above, assert rst_i during the HELD cycle → no write of the held load; outputs zero; state EMPTY the next cycle.
  - With RV32_WB_FWD_EN: rs1_addr_i=3 during the x3 write → rs1_fwd_hit_o=1, rs1_fwd_data_o=0xA.
